// File: rtl/pdm_decimator_pkg.sv
// Shared CIC constants and width helpers for the PDM decimator.
package pdm_decimator_pkg;

  localparam int CIC_ORDER = 3;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Bit growth of an N-stage CIC with differential delay 1.
  function automatic int cic_width(input int decimation);
    return CIC_ORDER * clog2(decimation);
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb section: a single delay register and a subtractor, advanced on dec_tick.
module cic_comb_stage #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] dly_q, dly_d;

  always_comb begin
    dly_d = dly_q;
    if (en) dly_d = din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dly_q <= '0;
    else        dly_q <= dly_d;
  end

  assign dout = din - dly_q;

endmodule

// File: rtl/pdm_decimator.sv
// 3rd-order CIC decimator turning a 1-bit PDM stream into unsigned offset-binary PCM.
module pdm_decimator
  import pdm_decimator_pkg::*;
#(
  parameter int DATA_BITS  = 12,
  parameter int DECIMATION = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pdm_in,
  input  logic                 pdm_en,
  output logic [DATA_BITS-1:0] sample_out,
  output logic                 sample_valid
);

  localparam int W     = cic_width(DECIMATION);
  localparam int CW    = W + 1;
  localparam int CNT_W = clog2(DECIMATION);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DECIMATION - 1);
  localparam logic [CW-1:0]    FULL_SCALE = {1'b1, {W{1'b0}}};

  if (W < DATA_BITS) begin : g_width_check
    $error("pdm_decimator: 3*log2(DECIMATION) must be >= DATA_BITS");
  end
  if (DECIMATION < 16 || DECIMATION > 256 || (1 << CNT_W) != DECIMATION) begin : g_dec_check
    $error("pdm_decimator: DECIMATION must be a power of two in 16..256");
  end

  // A constant all-ones input reaches exactly 2^W, one past the truncated range.
  function automatic logic [DATA_BITS-1:0] rescale(input logic [CW-1:0] c);
    if (c == FULL_SCALE) return '1;
    return c[W-1 -: DATA_BITS];
  endfunction

  logic [CW-1:0]        i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 dec_tick_q, dec_tick_d;
  logic [1:0]           warm_q, warm_d;
  logic [DATA_BITS-1:0] sample_q, sample_d;
  logic                 valid_q, valid_d;
  logic [CW-1:0]        c1, c2, c3;

  // Integrator stage: modulo accumulation, wrap is intentional.
  always_comb begin
    i1_d = i1_q;
    i2_d = i2_q;
    i3_d = i3_q;
    cnt_d = cnt_q;
    dec_tick_d = 1'b0;
    if (pdm_en) begin
      i1_d = i1_q + {{W{1'b0}}, pdm_in};
      i2_d = i2_q + i1_q;
      i3_d = i3_q + i2_q;
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
      dec_tick_d = (cnt_q == CNT_LAST);
    end
  end

  // Comb stage: runs at the decimated rate on the pre-edge I3.
  cic_comb_stage #(.WIDTH(CW)) u_comb1 (.clk(clk), .rst_n(rst_n), .en(dec_tick_q), .din(i3_q), .dout(c1));
  cic_comb_stage #(.WIDTH(CW)) u_comb2 (.clk(clk), .rst_n(rst_n), .en(dec_tick_q), .din(c1),   .dout(c2));
  cic_comb_stage #(.WIDTH(CW)) u_comb3 (.clk(clk), .rst_n(rst_n), .en(dec_tick_q), .din(c2),   .dout(c3));

  // Output stage: the first three ticks only prime the comb delays.
  always_comb begin
    warm_d   = warm_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    if (dec_tick_q) begin
      if (warm_q == 2'd3) begin
        sample_d = rescale(c3);
        valid_d  = 1'b1;
      end else begin
        warm_d = warm_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i1_q       <= '0;
      i2_q       <= '0;
      i3_q       <= '0;
      cnt_q      <= '0;
      dec_tick_q <= 1'b0;
      warm_q     <= '0;
      sample_q   <= '0;
      valid_q    <= 1'b0;
    end else begin
      i1_q       <= i1_d;
      i2_q       <= i2_d;
      i3_q       <= i3_d;
      cnt_q      <= cnt_d;
      dec_tick_q <= dec_tick_d;
      warm_q     <= warm_d;
      sample_q   <= sample_d;
      valid_q    <= valid_d;
    end
  end

  assign sample_out   = sample_q;
  assign sample_valid = valid_q;

endmodule

// File: tb/tb_pdm_decimator.sv
// Directed bench for pdm_decimator at DATA_BITS=12, DECIMATION=32.
module tb_pdm_decimator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pdm_in = 1'b0;
  logic        pdm_en = 1'b0;
  logic [11:0] sample_out;
  logic        sample_valid;

  int checks = 0;
  int errors = 0;

  int          cyc = 0;
  int          mode = 0;     // 0 zeros, 1 ones, 2 alternating, 3 quarter density, 4 sigma-delta loopback
  int          en_div = 1;
  int          bit_idx = 0;
  logic [11:0] din = 12'h000;
  logic [11:0] sd_acc = 12'h000;
  int          vcyc[$];
  logic [11:0] vval[$];

  pdm_decimator #(.DATA_BITS(12), .DECIMATION(32)) dut (
    .clk(clk), .rst_n(rst_n), .pdm_in(pdm_in), .pdm_en(pdm_en),
    .sample_out(sample_out), .sample_valid(sample_valid)
  );

  always #5 clk = ~clk;

  // Called at a falling edge; drives one bit, samples after the rising edge.
  task automatic step();
    logic [12:0] s;
    s = {1'b0, sd_acc} + {1'b0, din};
    pdm_en = ((cyc % en_div) == 0);
    case (mode)
      0: pdm_in = 1'b0;
      1: pdm_in = 1'b1;
      2: pdm_in = (bit_idx % 2) == 0;
      3: pdm_in = (bit_idx % 4) == 0;
      default: pdm_in = s[12];
    endcase
    if (pdm_en) begin
      bit_idx++;
      if (mode == 4) sd_acc = s[11:0];
    end
    @(posedge clk);
    #1;
    cyc++;
    if (sample_valid) begin
      vcyc.push_back(cyc);
      vval.push_back(sample_out);
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    cyc = 0;
    bit_idx = 0;
    sd_acc = 12'h000;
    vcyc.delete();
    vval.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    pdm_en = 1'b0;
    pdm_in = 1'b0;
    @(negedge clk);
    release_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (sample_out !== 12'h000) begin
      errors++;
      $display("FAIL reset_sample_out: got %h expected 000", sample_out);
    end
    checks++;
    if (sample_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_sample_valid: got %b expected 0", sample_valid);
    end
  endtask

  task automatic test_ones();
    mode = 1; en_div = 1;
    do_reset();
    run(225);
    checks++;
    if (vcyc.size() != 4) begin
      errors++;
      $display("FAIL ones_count: got %0d pulses expected 4", vcyc.size());
    end
    if (vcyc.size() >= 4) begin
      checks++;
      if (vcyc[0] != 129) begin
        errors++;
        $display("FAIL ones_first_latency: got cycle %0d expected 129", vcyc[0]);
      end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (vval[i] !== 12'hFFF) begin
          errors++;
          $display("FAIL ones_value[%0d]: got %h expected fff", i, vval[i]);
        end
      end
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (vcyc[i] - vcyc[i-1] != 32) begin
          errors++;
          $display("FAIL ones_spacing[%0d]: got %0d expected 32", i, vcyc[i] - vcyc[i-1]);
        end
      end
    end
  endtask

  task automatic test_zeros();
    mode = 0; en_div = 1;
    do_reset();
    run(300);
    checks++;
    if (vcyc.size() != 6) begin
      errors++;
      $display("FAIL zeros_count: got %0d pulses expected 6", vcyc.size());
    end
    if (vcyc.size() > 0) begin
      checks++;
      if (vcyc[0] != 129) begin
        errors++;
        $display("FAIL zeros_first_latency: got cycle %0d expected 129", vcyc[0]);
      end
      foreach (vval[i]) begin
        checks++;
        if (vval[i] !== 12'h000) begin
          errors++;
          $display("FAIL zeros_value[%0d]: got %h expected 000", i, vval[i]);
        end
      end
    end
  endtask

  task automatic test_patterns();
    logic [11:0] exp_val [2];
    exp_val[0] = 12'h800;
    exp_val[1] = 12'h400;
    for (int p = 0; p < 2; p++) begin
      mode = 2 + p; en_div = 1;
      do_reset();
      run(200);
      checks++;
      if (vcyc.size() != 3) begin
        errors++;
        $display("FAIL pattern%0d_count: got %0d pulses expected 3", p, vcyc.size());
      end
      foreach (vval[i]) begin
        checks++;
        if (vval[i] !== exp_val[p]) begin
          errors++;
          $display("FAIL pattern%0d_value[%0d]: got %h expected %h", p, i, vval[i], exp_val[p]);
        end
      end
    end
  endtask

  task automatic test_loopback();
    int n0;
    int d;
    mode = 4; en_div = 1; din = 12'h9C4;
    do_reset();
    run(320);
    n0 = vval.size();
    checks++;
    if (n0 != 6) begin
      errors++;
      $display("FAIL loop_count: got %0d pulses expected 6", n0);
    end
    for (int i = 4; i < 6; i++) begin
      if (i < n0) begin
        d = int'(vval[i]) - int'(12'h9C4);
        checks++;
        if (d > 2 || d < -2) begin
          errors++;
          $display("FAIL loop_9c4[%0d]: got %h expected 9c4 +/-2", i, vval[i]);
        end
      end
    end
    din = 12'h200;
    run(224);
    checks++;
    if (vval.size() != n0 + 7) begin
      errors++;
      $display("FAIL loop_step_count: got %0d pulses expected %0d", vval.size(), n0 + 7);
    end
    for (int i = n0 + 4; i < n0 + 6; i++) begin
      if (i < vval.size()) begin
        d = int'(vval[i]) - int'(12'h200);
        checks++;
        if (d > 2 || d < -2) begin
          errors++;
          $display("FAIL loop_200[%0d]: got %h expected 200 +/-2", i, vval[i]);
        end
      end
    end
  endtask

  task automatic test_sparse_enable();
    mode = 1; en_div = 4;
    do_reset();
    run(640);
    checks++;
    if (vcyc.size() != 2) begin
      errors++;
      $display("FAIL sparse_count: got %0d pulses expected 2", vcyc.size());
    end
    if (vcyc.size() >= 2) begin
      checks++;
      if (vcyc[0] != 510) begin
        errors++;
        $display("FAIL sparse_first_latency: got cycle %0d expected 510", vcyc[0]);
      end
      checks++;
      if (vcyc[1] - vcyc[0] != 128) begin
        errors++;
        $display("FAIL sparse_spacing: got %0d expected 128", vcyc[1] - vcyc[0]);
      end
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (vval[i] !== 12'hFFF) begin
          errors++;
          $display("FAIL sparse_value[%0d]: got %h expected fff", i, vval[i]);
        end
      end
    end
    en_div = 1;
  endtask

  task automatic test_reset_mid();
    mode = 1; en_div = 1;
    do_reset();
    run(210);
    checks++;
    if (sample_out !== 12'hFFF) begin
      errors++;
      $display("FAIL mid_pre_value: got %h expected fff", sample_out);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (sample_out !== 12'h000 || sample_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_async_clear: got out=%h valid=%b expected 000/0", sample_out, sample_valid);
    end
    @(negedge clk);
    release_reset();
    run(135);
    checks++;
    if (vcyc.size() != 1) begin
      errors++;
      $display("FAIL mid_count: got %0d pulses expected 1", vcyc.size());
    end
    if (vcyc.size() >= 1) begin
      checks++;
      if (vcyc[0] != 129 || vval[0] !== 12'hFFF) begin
        errors++;
        $display("FAIL mid_restart: got cycle %0d value %h expected 129/fff", vcyc[0], vval[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ones();
    test_zeros();
    test_patterns();
    test_loopback();
    test_sparse_enable();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
